// File: rtl/uart_loader.sv
`default_nettype none
// ============================================================================
// Module : uart_loader
// Brief  : UART (8N1) boot loader that streams a length-prefixed image into
//          word-addressed program/data memory through a one-cycle strobe.
// Rev    : 1.0
// ============================================================================
module uart_loader #(
    parameter int CLK_PER_BIT = 868,
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_pg,
    input  logic              rx,
    output logic              upg_wen_o,
    output logic [ADDR_W-1:0] upg_adr_o,
    output logic [DATA_W-1:0] upg_dat_o,
    output logic              upg_busy_o,
    output logic              upg_done_o,
    output logic              upg_err_o
);

    localparam int NB   = DATA_W / 8;
    localparam int BI_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int CW   = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0]   C_BIT_END  = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0]   C_HALF_END = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [BI_W-1:0] C_LAST_BYTE = BI_W'(NB - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_WRITE, S_DONE, S_ERR} state_e;

    logic              rx_s1_q, rx_s2_q, rx_s3_q;
    logic              sp_q;
    rx_state_e         rxs_q, rxs_d;
    logic [CW-1:0]     rcnt_q, rcnt_d;
    logic [2:0]        rbit_q, rbit_d;
    logic [7:0]        rsh_q, rsh_d;
    logic              w_byte_vld, w_frame_err, w_sp_edge;

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       wcnt_q, wcnt_d;
    logic [BI_W-1:0]   bidx_q, bidx_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [ADDR_W-1:0] nadr_q, nadr_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] dat_q, dat_d;

    assign w_sp_edge = start_pg && !sp_q;

    // Receiver: rx_s3_q is the previous synchronised sample for edge detection.
    always_comb begin
        rxs_d       = rxs_q;
        rcnt_d      = rcnt_q + CW'(1);
        rbit_d      = rbit_q;
        rsh_d       = rsh_q;
        w_byte_vld  = 1'b0;
        w_frame_err = 1'b0;
        case (rxs_q)
            RX_IDLE: begin
                rcnt_d = '0;
                if (rx_s3_q && !rx_s2_q) rxs_d = RX_START;
            end
            RX_START: begin
                if (rcnt_q == C_HALF_END) begin
                    rcnt_d = '0;
                    rbit_d = '0;
                    rxs_d  = rx_s2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rcnt_q == C_BIT_END) begin
                    rcnt_d = '0;
                    rsh_d  = {rx_s2_q, rsh_q[7:1]};
                    rbit_d = rbit_q + 3'd1;
                    if (rbit_q == 3'd7) rxs_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rcnt_q == C_BIT_END) begin
                    rcnt_d = '0;
                    rxs_d  = RX_IDLE;
                    if (rx_s2_q) w_byte_vld  = 1'b1;
                    else         w_frame_err = 1'b1;
                end
            end
            default: rxs_d = RX_IDLE;
        endcase
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        bidx_d  = bidx_q;
        word_d  = word_q;
        nadr_d  = nadr_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (w_sp_edge) begin
                    state_d = S_LEN;
                    nadr_d  = '0;
                    bidx_d  = '0;
                    wcnt_d  = '0;
                end
            end
            S_LEN: begin
                if (w_frame_err) begin
                    state_d = S_ERR;
                end else if (w_byte_vld) begin
                    if (bidx_q == '0) begin
                        len_d[7:0] = rsh_q;
                        bidx_d     = BI_W'(1);
                    end else begin
                        len_d[15:8] = rsh_q;
                        bidx_d      = '0;
                        state_d     = ({rsh_q, len_q[7:0]} == 16'd0) ? S_DONE : S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_frame_err) begin
                    state_d = S_ERR;
                end else if (w_byte_vld) begin
                    for (int i = 0; i < NB; i++) begin
                        if (bidx_q == BI_W'(i)) word_d[i*8 +: 8] = rsh_q;
                    end
                    if (bidx_q == C_LAST_BYTE) begin
                        bidx_d  = '0;
                        dat_d   = word_d;
                        adr_d   = nadr_q;
                        state_d = S_WRITE;
                    end else begin
                        bidx_d = bidx_q + BI_W'(1);
                    end
                end
            end
            S_WRITE: begin
                nadr_d  = nadr_q + ADDR_W'(1);
                wcnt_d  = wcnt_q + 16'd1;
                state_d = (wcnt_d == len_q) ? S_DONE : S_DATA;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
            sp_q    <= 1'b0;
            rxs_q   <= RX_IDLE;
            rcnt_q  <= '0;
            rbit_q  <= '0;
            rsh_q   <= '0;
            state_q <= S_IDLE;
            len_q   <= '0;
            wcnt_q  <= '0;
            bidx_q  <= '0;
            word_q  <= '0;
            nadr_q  <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
            sp_q    <= start_pg;
            rxs_q   <= rxs_d;
            rcnt_q  <= rcnt_d;
            rbit_q  <= rbit_d;
            rsh_q   <= rsh_d;
            state_q <= state_d;
            len_q   <= len_d;
            wcnt_q  <= wcnt_d;
            bidx_q  <= bidx_d;
            word_q  <= word_d;
            nadr_q  <= nadr_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
        end
    end

    assign upg_wen_o  = (state_q == S_WRITE);
    assign upg_adr_o  = adr_q;
    assign upg_dat_o  = dat_q;
    assign upg_busy_o = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_WRITE);
    assign upg_done_o = (state_q == S_DONE);
    assign upg_err_o  = (state_q == S_ERR);

endmodule
`default_nettype wire

// File: doc/uart_loader.md
UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 Parameter: CLK_PER_BIT, default 868, clk cycles per UART bit; legal values are 4 or more.
REQ-002 Parameter: ADDR_W, default 15, width of the word address; the MSB selects the target (0 = program ROM, 1 = data memory).
REQ-003 Parameter: DATA_W, default 32, word width; SHALL be a multiple of 8.
REQ-004 Port: clk, input, 1, sole clock; all state changes on its rising edge.
REQ-005 Port: rst, input, 1, reset; asynchronous, active-low.
REQ-006 Port: start_pg, input, 1, synchronous level request to enter programming mode; rising edge detected internally.
REQ-007 Port: rx, input, 1, UART serial in (8N1, idle high); asynchronous to clk.
REQ-008 Port: upg_wen_o, output, 1, one-cycle memory write strobe.
REQ-009 Port: upg_adr_o, output, ADDR_W, word address of the current write.
REQ-010 Port: upg_dat_o, output, DATA_W, word being written.
REQ-011 Port: upg_busy_o, output, 1, high while in LEN, DATA or WRITE.
REQ-012 Port: upg_done_o, output, 1, load complete; the CPU may run when this is high.
REQ-013 Port: upg_err_o, output, 1, framing error latched.

Function
REQ-014 rx SHALL pass through a 2-flop synchroniser before any use; all rx timing below is measured on the synchronised signal.
REQ-015 Receiver start detection: a falling edge starts the bit timer; the line is re-sampled CLK_PER_BIT/2 (integer division) cycles later; if it is high, the event is a glitch and the receiver returns to idle silently.
REQ-016 Receiver sampling: the 8 data bits are sampled LSB first, each CLK_PER_BIT cycles after the previous sample; the stop bit is sampled CLK_PER_BIT cycles after bit 7.
REQ-017 Receiver stop bit: if the stop bit is low, the FSM SHALL enter ERR; otherwise a byte-valid event SHALL be raised for one cycle.
REQ-018 FSM states SHALL be IDLE, LEN, DATA, WRITE, DONE and ERR.
REQ-019 IDLE/DONE/ERR -> LEN on a start_pg rising edge; this transition clears upg_done_o, upg_err_o, the address, the byte index and the word count.
REQ-020 A start_pg edge in LEN, DATA or WRITE SHALL be ignored.
REQ-021 Bytes received while in IDLE, DONE or ERR SHALL be discarded.
REQ-022 LEN: the first two bytes form the 16-bit word count N, little-endian; after the second byte, go to DATA if N > 0, else go to DONE.
REQ-023 DATA: DATA_W/8 bytes assemble one word, little-endian (first byte = bits 7:0); after the last byte of a word, go to WRITE.
REQ-024 WRITE lasts exactly 1 cycle: upg_wen_o = 1 with upg_adr_o and upg_dat_o stable; then the address increments (modulo 2^ADDR_W, wrapping silently) and the written-word count increments.
REQ-025 After WRITE: go to DONE if the written count equals N, else go to DATA.
REQ-026 Write latency: upg_wen_o SHALL assert on the cycle after the byte-valid event of the word's last byte.
REQ-027 DONE: upg_done_o = 1, held until the next accepted start_pg; upg_wen_o is never asserted outside WRITE.
REQ-028 ERR: upg_err_o = 1, held; no further writes; exit only via start_pg.
REQ-029 upg_adr_o and upg_dat_o SHALL hold their last values outside WRITE.

Reset
REQ-030 While rst = 0: state = IDLE; upg_wen_o = 0; upg_adr_o = 0; upg_dat_o = 0; upg_busy_o = 0; upg_err_o = 0; upg_done_o = 0; receiver idle; synchroniser flops = 1.
REQ-031 Reset asserted mid-frame or mid-load SHALL abort immediately with no further write strobe; after release, the block waits for start_pg.

Verification (CLK_PER_BIT = 16, ADDR_W = 15, DATA_W = 32)
REQ-032 Normal load: start_pg, then bytes 02 00 | 13 00 50 00 | 93 00 10 00 -> writes (0x0000, 0x00500013), then (0x0001, 0x00100093); upg_done_o = 1 one cycle after the 2nd strobe.
REQ-033 Zero length: start_pg, then bytes 00 00 -> no upg_wen_o; upg_done_o = 1; upg_busy_o = 0.
REQ-034 Framing error: stop bit forced low on the 3rd byte -> upg_err_o = 1, no write; a new start_pg plus a valid 1-word load -> write at address 0x0000, upg_err_o = 0.
REQ-035 Glitch: a 4-cycle low pulse on rx in LEN -> no byte accepted; the following valid length bytes 01 00 are parsed correctly.
REQ-036 Wrap and ignore: start address forced to 0x7FFF via a 2-word load -> second write at 0x0000; a start_pg pulse mid-load -> no effect on the load.
REQ-037 Async reset: rst = 0 asserted during the 2nd data byte -> all outputs 0 within the same cycle; no strobe follows after release.
